// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, hc/vc counters, delayed sync/blank, frame tick
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_tick,
    output logic [9:0]  frame_count
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS_L  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_L  = 11'(V_VIS);

    logic [DIV_W-1:0] div;
    logic             h_last;
    logic             v_last;
    logic [2:0]       raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    assign h_last = (hc == H_LAST);
    assign v_last = (vc == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hc <= '0;
                vc <= v_last ? '0 : vc + 11'd1;
            end else begin
                hc <= hc + 11'd1;
            end
        end
    end

    // Pulses in the cycle the wrap to (0,0) is being latched; rst suppresses a stray pulse.
    assign frame_tick = pix_en & h_last & v_last & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (frame_tick) begin
            frame_count <= frame_count + 10'd1;
        end
    end

    assign raw = {~((hc >= HS_START) && (hc < HS_END)),
                  ~((vc >= VS_START) && (vc < VS_END)),
                  (hc >= H_VIS_L) || (vc >= V_VIS_L)};

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign {hsync, vsync, blank} = raw;
        end else begin : g_dly
            // Stages hold {hs, vs, bl}; reset to inactive sync and blanked video.
            logic [2:0] dly_q [PIPE_DLY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        dly_q[i] <= 3'b111;
                    end
                end else if (pix_en) begin
                    dly_q[0] <= raw;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign {hsync, vsync, blank} = dly_q[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen over small and default rasters
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        pe_a, hs_a, vs_a, bl_a, ft_a;
    logic [10:0] hc_a, vc_a;
    logic [9:0]  fc_a;
    logic        pe_b, hs_b, vs_b, bl_b, ft_b;
    logic [10:0] hc_b, vc_b;
    logic [9:0]  fc_b;
    logic        pe_c, hs_c, vs_c, bl_c, ft_c;
    logic [10:0] hc_c, vc_c;
    logic [9:0]  fc_c;

    int checks = 0;
    int failures = 0;

    // Small raster: 15 x 8, hsync low hc 10..12, vsync low vc 5..6, visible 8 x 4.
    vga_timing_gen #(
        .CLK_DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(1)
    ) u_a (
        .clk(clk), .rst(rst), .pix_en(pe_a), .hc(hc_a), .vc(vc_a),
        .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .frame_tick(ft_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(0)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pe_b), .hc(hc_b), .vc(vc_b),
        .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .frame_tick(ft_b), .frame_count(fc_b)
    );

    vga_timing_gen #(
        .PIPE_DLY(0)
    ) u_c (
        .clk(clk), .rst(rst), .pix_en(pe_c), .hc(hc_c), .vc(vc_c),
        .hsync(hs_c), .vsync(vs_c), .blank(bl_c), .frame_tick(ft_c), .frame_count(fc_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k = clk edges since rst was released (0 while in reset).
    task automatic check_dut(input string tag, input int cdiv, input int pdly,
                             input int ht, input int vt, input int hvis, input int hfp, input int hsw,
                             input int vvis, input int vfp, input int vsw, input int k,
                             input logic pe, input logic [10:0] h, input logic [10:0] v,
                             input logic hs, input logic vs, input logic bl,
                             input logic ft, input logic [9:0] fc);
        int p, pos, hce, vce, fce, q, qh, qv;
        logic pee, fte;
        logic [2:0] sb;
        pee = (k >= 1) && (k % cdiv == 0);
        p   = (k >= 1) ? (k - 1) / cdiv : 0;
        pos = p % (ht * vt);
        hce = pos % ht;
        vce = pos / ht;
        fce = (p / (ht * vt)) % 1024;
        fte = pee && (hce == ht - 1) && (vce == vt - 1);
        if (pdly == 0) q = pos;
        else q = (p >= pdly) ? (p - pdly) % (ht * vt) : -1;
        if (q < 0) begin
            sb = 3'b111;
        end else begin
            qh = q % ht;
            qv = q / ht;
            sb = {!((qh >= hvis + hfp) && (qh < hvis + hfp + hsw)),
                  !((qv >= vvis + vfp) && (qv < vvis + vfp + vsw)),
                  (qh >= hvis) || (qv >= vvis)};
        end
        check({tag, "_pix_en"}, 32'(pe), 32'(pee));
        check({tag, "_hc"}, 32'(h), 32'(hce));
        check({tag, "_vc"}, 32'(v), 32'(vce));
        check({tag, "_hsync"}, 32'(hs), 32'(sb[2]));
        check({tag, "_vsync"}, 32'(vs), 32'(sb[1]));
        check({tag, "_blank"}, 32'(bl), 32'(sb[0]));
        check({tag, "_frame_tick"}, 32'(ft), 32'(fte));
        check({tag, "_frame_count"}, 32'(fc), 32'(fce));
    endtask

    task automatic sweep_all(input int k);
        check_dut("a", 4, 1, 15, 8, 8, 2, 3, 4, 1, 2, k,
                  pe_a, hc_a, vc_a, hs_a, vs_a, bl_a, ft_a, fc_a);
        check_dut("b", 1, 0, 15, 8, 8, 2, 3, 4, 1, 2, k,
                  pe_b, hc_b, vc_b, hs_b, vs_b, bl_b, ft_b, fc_b);
        check_dut("c", 4, 0, 800, 525, 640, 16, 96, 480, 10, 2, k,
                  pe_c, hc_c, vc_c, hs_c, vs_c, bl_c, ft_c, fc_c);
    endtask

    task automatic directed(input int k);
        case (k)
            1:    begin check("b_first_pe", 32'(pe_b), 1); check("b_hc_k1", 32'(hc_b), 0); end
            2:    check("b_hc_k2", 32'(hc_b), 1);
            3:    check("a_no_pe_k3", 32'(pe_a), 0);
            4:    begin check("a_first_pe", 32'(pe_a), 1); check("a_hc_k4", 32'(hc_a), 0); end
            5:    begin check("a_hc_k5", 32'(hc_a), 1); check("a_pe_k5", 32'(pe_a), 0); end
            44:   check("a_hsync_pre", 32'(hs_a), 1);
            45:   check("a_hsync_fall", 32'(hs_a), 0);
            120:  check("b_frame_tick", 32'(ft_b), 1);
            121:  begin check("b_fc1", 32'(fc_b), 1); check("b_hc_wrap", 32'(hc_b), 0); end
            480:  check("a_frame_tick", 32'(ft_a), 1);
            481:  begin check("a_fc1", 32'(fc_a), 1); check("a_vc_wrap", 32'(vc_a), 0); end
            484:  check("a_blank_pre", 32'(bl_a), 1);
            485:  check("a_blank_fall", 32'(bl_a), 0);
            961:  check("a_fc2", 32'(fc_a), 2);
            2557: check("c_blank_639", 32'(bl_c), 0);
            2561: check("c_blank_640", 32'(bl_c), 1);
            2621: check("c_hsync_655", 32'(hs_c), 1);
            2625: check("c_hsync_656", 32'(hs_c), 0);
            3005: check("c_hsync_751", 32'(hs_c), 0);
            3009: check("c_hsync_752", 32'(hs_c), 1);
            3197: begin check("c_hc_799", 32'(hc_c), 799); check("c_vc_line0", 32'(vc_c), 0); end
            3201: begin check("c_hc_wrap", 32'(hc_c), 0); check("c_vc_line1", 32'(vc_c), 1); end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) begin
            tick();
            sweep_all(0);
        end
        check("rst_a_hsync", 32'(hs_a), 1);
        check("rst_a_vsync", 32'(vs_a), 1);
        check("rst_a_blank", 32'(bl_a), 1);
        check("rst_a_fc", 32'(fc_a), 0);
        check("rst_c_blank_raw", 32'(bl_c), 0);
        rst = 1'b0;

        for (int k = 1; k <= 3300; k++) begin
            tick();
            sweep_all(k);
            directed(k);
        end

        rst = 1'b1;
        tick();
        sweep_all(0);
        check("mid_rst_a_hc", 32'(hc_a), 0);
        check("mid_rst_a_vc", 32'(vc_a), 0);
        check("mid_rst_a_blank", 32'(bl_a), 1);
        check("mid_rst_a_fc", 32'(fc_a), 0);
        check("mid_rst_c_vc", 32'(vc_c), 0);
        rst = 1'b0;

        for (int k = 1; k <= 1000; k++) begin
            tick();
            sweep_all(k);
            if (k == 479) check("post_rst_a_no_tick", 32'(ft_a), 0);
            if (k == 480) check("post_rst_a_tick", 32'(ft_a), 1);
            if (k == 481) check("post_rst_a_fc1", 32'(fc_a), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the board clock.
- Drives pixel coordinates hc/vc into the background and foreground sprite address stages.
- Produces hsync/vsync/blank delayed by the pixel-pipeline latency, so they line up with ROM pixel data at the DAC.
- Provides a pixel enable strobe and a frame tick/counter, used by the sprite stages to step animation offsets (e.g. sprite_num).

Parameters:
- CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz); legal values are 1 or more.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- PIPE_DLY, 1, pixel ticks of delay applied to hsync/vsync/blank; range 0 to 4.

Ports:
- clk, in, 1, board clock.
- rst, in, 1, synchronous active-high reset.
- pix_en, out, 1, one-clk strobe; counters advance on it.
- hc, out, 11, horizontal pixel count, 0..H_TOTAL-1.
- vc, out, 11, vertical line count, 0..V_TOTAL-1.
- hsync, out, 1, active-low, delayed PIPE_DLY pixel ticks.
- vsync, out, 1, active-low, delayed PIPE_DLY pixel ticks.
- blank, out, 1, high outside the visible area, delayed PIPE_DLY pixel ticks.
- frame_tick, out, 1, one-clk pulse at the end of each frame.
- frame_count, out, 10, count of frames completed, wraps.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst; every register is cleared on a rising clk edge with rst=1. No asynchronous reset.
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525 (default parameters).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1), registered.
  - With CLK_DIV=1, pix_en is constantly 1 after reset.
- Counters, updated only on clk edges where pix_en=1:
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps from V_TOTAL-1 to 0 at the same edge that hc wraps.
- Raw decode, combinational from registered hc/vc:
  - hs_raw = 0 when H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw = 0 when V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491).
  - bl_raw = (hc >= H_VIS) | (vc >= V_VIS).
- Delay line:
  - PIPE_DLY stages of {hs,vs,bl}, each stage loads only on pix_en.
  - With PIPE_DLY=0, outputs equal the raw decode.
  - hc/vc themselves are never delayed.
- frame_tick = 1 for exactly one clk when pix_en=1 and hc==H_TOTAL-1 and vc==V_TOTAL-1, i.e. the same cycle the wrap to (0,0) is being latched.
- frame_count increments on frame_tick and wraps 1023 -> 0.
- Reset values:
  - div=0, pix_en=0, hc=0, vc=0, frame_tick=0, frame_count=0.
  - All delay stages and the outputs hsync=1, vsync=1, blank=1 (inactive/blanked until the pipeline fills).
- Reset mid-frame: the next edge forces the reset values regardless of pix_en. Counting resumes from (0,0) with the first pix_en CLK_DIV clks after rst falls. No partial frame_tick is produced.
- Boundaries:
  - hc never reaches H_TOTAL; vc never reaches V_TOTAL.
  - At hc=H_TOTAL-1, vc=V_TOTAL-1, wrapping both counters and pulsing frame_tick occur in the same cycle.
- Latency: hc/vc change 1 clk after pix_en is sampled high. Sync/blank lag the matching hc/vc by PIPE_DLY pixel ticks.

Test Plan:
- Reset -> hold rst 3 clks then release; expect hc=vc=0, hsync=vsync=blank=1, frame_count=0. First pix_en at clk 4 after release (CLK_DIV=4); hc=1 one clk later.
- Line timing, PIPE_DLY=0 -> hsync low exactly for hc 656..751 (96 pixel ticks = 384 clks). blank rises at hc=640. After hc=799, hc=0 and vc increments by 1.
- Frame timing -> vsync low only for vc 490..491. frame_tick pulses once every 800*525*4 = 1,680,000 clks. frame_count reads 2 after two frames.
- PIPE_DLY=1 -> hsync falls one pixel tick (4 clks) after hc becomes 656. blank falls one tick after hc wraps to 0 on vc=0.
- Reset mid-frame at vc=300, hc=500 -> next clk hc=vc=0, outputs at reset values. No frame_tick until a full 800x525 frame completes. frame_count is unchanged from 0.
- CLK_DIV=1 -> pix_en held high; hc advances every clk. frame_tick period is 420,000 clks.
